// File: rtl/regfile_banked.sv
// Banked multi-read-port register file with one-cycle write-first reads and a walking clear.
// Define REGFILE_ZERO_REG_EN to hardwire address 0 of every bank to zero.
module regfile_banked #(
  parameter int unsigned REGADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REGS       = 1 << REGADDR_WIDTH,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned NUM_BANKS      = 1,
  localparam int unsigned BANK_WIDTH    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_READ_PORTS*BANK_WIDTH-1:0]    readBank,
  input  logic [NUM_READ_PORTS*REGADDR_WIDTH-1:0] readAddr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    readData,
  input  logic [BANK_WIDTH-1:0]                   writeBank,
  input  logic [REGADDR_WIDTH-1:0]                writeAddr,
  input  logic [DATA_WIDTH-1:0]                   writeData,
  input  logic                                    writeEnable,
  input  logic [BANK_WIDTH-1:0]                   clearBank,
  input  logic                                    clearStart,
  output logic                                    clearBusy,
  output logic                                    clearDone
);

  localparam int unsigned Entries = NUM_BANKS * NUM_REGS;
  localparam int unsigned IdxW    = (Entries > 1) ? $clog2(Entries) : 1;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StClrAll, StClrOne} state_e;

  state_e                   state_q, state_d;
  logic [BANK_WIDTH-1:0]    clr_bank_q, clr_bank_d;
  logic [BANK_WIDTH-1:0]    cnt_bank_q, cnt_bank_d;
  logic [REGADDR_WIDTH-1:0] cnt_addr_q, cnt_addr_d;
  logic                     done_q, done_d;

  logic [DATA_WIDTH-1:0] mem_q [Entries];
  logic                  mem_we;
  logic [IdxW-1:0]       mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  clearing, clr_last, wr_ok;
  logic [BANK_WIDTH-1:0] clr_wbank;

  function automatic logic [IdxW-1:0] entry_idx(input logic [BANK_WIDTH-1:0]    b,
                                                input logic [REGADDR_WIDTH-1:0] a);
    return IdxW'(IdxW'(b) * IdxW'(NUM_REGS) + IdxW'(a));
  endfunction

  function automatic logic entry_ok(input logic [BANK_WIDTH-1:0]    b,
                                    input logic [REGADDR_WIDTH-1:0] a);
    return (32'(b) < NUM_BANKS) && (32'(a) < NUM_REGS);
  endfunction

  function automatic logic is_zero_reg(input logic [REGADDR_WIDTH-1:0] a);
    return ZeroReg && (a == '0);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StClrAll;
      clr_bank_q <= '0;
      cnt_bank_q <= '0;
      cnt_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_bank_q <= clr_bank_d;
      cnt_bank_q <= cnt_bank_d;
      cnt_addr_q <= cnt_addr_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; the counter walks {bank, addr}
  always_comb begin
    state_d    = state_q;
    clr_bank_d = clr_bank_q;
    cnt_bank_d = cnt_bank_q;
    cnt_addr_d = cnt_addr_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (clearStart) begin
          state_d    = StClrOne;
          clr_bank_d = clearBank;
          cnt_bank_d = '0;
          cnt_addr_d = '0;
        end
      end
      StClrAll, StClrOne: begin
        if (clr_last) begin
          state_d    = StIdle;
          done_d     = 1'b1;
          cnt_bank_d = '0;
          cnt_addr_d = '0;
        end else if (32'(cnt_addr_q) == NUM_REGS - 1) begin
          cnt_addr_d = '0;
          cnt_bank_d = cnt_bank_q + 1'b1;
        end else begin
          cnt_addr_d = cnt_addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and storage write selection
  always_comb begin
    clearing  = (state_q != StIdle);
    clr_wbank = (state_q == StClrOne) ? clr_bank_q : cnt_bank_q;
    clr_last  = (32'(cnt_addr_q) == NUM_REGS - 1) &&
                ((state_q == StClrOne) || (32'(cnt_bank_q) == NUM_BANKS - 1));
    wr_ok     = writeEnable && (state_q == StIdle) && entry_ok(writeBank, writeAddr) &&
                !is_zero_reg(writeAddr);
    mem_we    = !reset && ((clearing && (32'(clr_wbank) < NUM_BANKS)) || wr_ok);
    mem_widx  = clearing ? entry_idx(clr_wbank, cnt_addr_q) : entry_idx(writeBank, writeAddr);
    mem_wdata = clearing ? '0 : writeData;
    clearBusy = clearing;
    clearDone = done_q;
  end

  // No reset term so the array stays RAM-inferable
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [BANK_WIDTH-1:0]    rbank;
    logic [REGADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0]    rdata_d, rdata_q;
    logic                     bank_clearing;

    assign rbank = readBank[p*BANK_WIDTH +: BANK_WIDTH];
    assign raddr = readAddr[p*REGADDR_WIDTH +: REGADDR_WIDTH];

    always_comb begin
      bank_clearing = (state_q == StClrAll) || ((state_q == StClrOne) && (rbank == clr_bank_q));
      rdata_d       = '0;
      if (bank_clearing || !entry_ok(rbank, raddr) || is_zero_reg(raddr)) begin
        rdata_d = '0;
      end else if (wr_ok && (rbank == writeBank) && (raddr == writeAddr)) begin
        rdata_d = writeData;
      end else begin
        rdata_d = mem_q[entry_idx(rbank, raddr)];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
    end

    assign readData[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
  end

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench for regfile_banked: two banks of 32 x 32-bit, two read ports.
module tb_regfile_banked;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] Addr0Val = 32'h0000_0000;
`else
  localparam logic [31:0] Addr0Val = 32'hFFFF_FFFF;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  readBank;
  logic [9:0]  readAddr;
  logic [63:0] readData;
  logic        writeBank;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        writeEnable;
  logic        clearBank;
  logic        clearStart;
  logic        clearBusy;
  logic        clearDone;

  int n_vec = 0;
  int n_err = 0;

  regfile_banked #(
    .REGADDR_WIDTH  (5),
    .DATA_WIDTH     (32),
    .NUM_REGS       (32),
    .NUM_READ_PORTS (2),
    .NUM_BANKS      (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .readBank    (readBank),
    .readAddr    (readAddr),
    .readData    (readData),
    .writeBank   (writeBank),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .clearBank   (clearBank),
    .clearStart  (clearStart),
    .clearBusy   (clearBusy),
    .clearDone   (clearDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        wb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rb0;
    logic [4:0]  ra0;
    logic        rb1;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_reads(input logic b0, input logic [4:0] a0,
                           input logic b1, input logic [4:0] a1);
    readBank = {b1, b0};
    readAddr = {a1, a0};
  endtask

  // Samples from now until clearBusy drops, then one extra cycle for a stray clearDone
  task automatic wait_idle(input bit check_zero, output int busy_cycles, output int done_pulses);
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (check_zero) begin
        check("clr_rd0_zero", readData[31:0], 32'h0);
        check("clr_rd1_zero", readData[63:32], 32'h0);
      end
      if (clearDone) done_pulses++;
      if (!clearBusy) break;
      busy_cycles++;
      tick();
    end
    tick();
    if (clearDone) done_pulses++;
  endtask

  initial begin
    int busy, dones, pre_dones;

    vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b1, 5'd6, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 1'b1, 5'd5, 32'h0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 5'd7, 32'h12345678, 1'b0, 5'd7, 1'b0, 5'd7,
                 32'h12345678, 32'h12345678};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 1'b1, 5'd7, 32'h12345678, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 1'b1, 5'd5,
                 32'h11111111, 32'h11111111};
    vecs[5]  = '{1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b1, 5'd5, Addr0Val, 32'h11111111};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, Addr0Val, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b0, 5'd31, 32'hCAFEF00D, 1'b0, 5'd31, 1'b1, 5'd31, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd31, 1'b1, 5'd5, 32'h0, 32'h11111111};
    vecs[9]  = '{1'b1, 1'b0, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd3, 1'b1, 5'd3, 32'hA5A5A5A5, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd3, 1'b1, 5'd3,
                 32'hA5A5A5A5, 32'hA5A5A5A5};

    reset = 1'b1; writeEnable = 1'b0; writeBank = 1'b0; writeAddr = '0; writeData = '0;
    clearStart = 1'b0; clearBank = 1'b0;
    set_reads(1'b0, 5'd3, 1'b1, 5'd5);
    repeat (3) tick();
    check("rst_rd0", readData[31:0], 32'h0);
    check("rst_rd1", readData[63:32], 32'h0);
    check("rst_busy", 32'(clearBusy), 32'd1);
    check("rst_done", 32'(clearDone), 32'd0);

    reset = 1'b0;
    wait_idle(1'b1, busy, dones);
    check("init_busy_cycles", busy, 32'd64);
    check("init_done_pulses", dones, 32'd1);

    for (int i = 0; i < 11; i++) begin
      writeEnable = vecs[i].we; writeBank = vecs[i].wb;
      writeAddr = vecs[i].wa; writeData = vecs[i].wd;
      set_reads(vecs[i].rb0, vecs[i].ra0, vecs[i].rb1, vecs[i].ra1);
      tick();
      check($sformatf("vec%0d_rd0", i), readData[31:0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), readData[63:32], vecs[i].e1);
    end

    // Clear bank 1 only; a write and a second clearStart mid-clear must be dropped
    writeEnable = 1'b0; clearStart = 1'b1; clearBank = 1'b1;
    set_reads(1'b0, 5'd3, 1'b1, 5'd3);
    tick();
    check("one_busy_start", 32'(clearBusy), 32'd1);
    check("one_rd0_start", readData[31:0], 32'hA5A5A5A5);
    check("one_rd1_start", readData[63:32], 32'hA5A5A5A5);
    clearBank = 1'b0; writeEnable = 1'b1; writeBank = 1'b0; writeAddr = 5'd3;
    writeData = 32'h0BADBAD0;
    tick();
    check("one_rd0_mid", readData[31:0], 32'hA5A5A5A5);
    check("one_rd1_mid", readData[63:32], 32'h0);
    clearStart = 1'b0; writeEnable = 1'b0;
    wait_idle(1'b0, busy, dones);
    check("one_busy_cycles", 1 + busy, 32'd32);
    check("one_done_pulses", dones, 32'd1);
    check("one_rd0_after", readData[31:0], 32'hA5A5A5A5);
    check("one_rd1_after", readData[63:32], 32'h0);
    set_reads(1'b0, 5'd7, 1'b1, 5'd5);
    tick();
    check("one_b0a7_kept", readData[31:0], 32'h12345678);
    check("one_b1a5_clr", readData[63:32], 32'h0);

    // Reset in the middle of a single-bank clear restarts as a full clear
    clearStart = 1'b1; clearBank = 1'b0;
    tick();
    clearStart = 1'b0;
    pre_dones = 0;
    repeat (10) begin
      tick();
      if (clearDone) pre_dones++;
    end
    check("abort_busy_pre", 32'(clearBusy), 32'd1);
    reset = 1'b1;
    tick();
    if (clearDone) pre_dones++;
    reset = 1'b0;
    wait_idle(1'b1, busy, dones);
    check("abort_no_done", pre_dones, 32'd0);
    check("abort_busy_cycles", busy, 32'd64);
    check("abort_done_pulses", dones, 32'd1);
    check("abort_b0a7", readData[31:0], 32'h0);
    check("abort_b1a5", readData[63:32], 32'h0);

    // Write and clearStart together: write lands first, survives unless in clearBank
    writeEnable = 1'b1; writeBank = 1'b0; writeAddr = 5'd9; writeData = 32'h55AA55AA;
    clearStart = 1'b1; clearBank = 1'b1;
    set_reads(1'b0, 5'd9, 1'b1, 5'd9);
    tick();
    check("sim0_fwd", readData[31:0], 32'h55AA55AA);
    writeEnable = 1'b0; clearStart = 1'b0;
    wait_idle(1'b0, busy, dones);
    check("sim0_busy_cycles", busy, 32'd32);
    check("sim0_kept", readData[31:0], 32'h55AA55AA);

    writeEnable = 1'b1; writeBank = 1'b1; writeAddr = 5'd9; writeData = 32'h77777777;
    clearStart = 1'b1; clearBank = 1'b1;
    tick();
    check("sim1_fwd", readData[63:32], 32'h77777777);
    writeEnable = 1'b0; clearStart = 1'b0;
    wait_idle(1'b0, busy, dones);
    check("sim1_done_pulses", dones, 32'd1);
    check("sim1_cleared", readData[63:32], 32'h0);
    check("sim1_other_bank", readData[31:0], 32'h55AA55AA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
- Multi-bank, multi-read-port register file for the nanomixer FPGA datapath. It generalises the single-bank two-read-port register file with a parametrised read-port count, bank (context) select and a hardware clear sequencer.
- Reads are synchronous with one-cycle latency and write-first forwarding.
- Reset and clearStart zero the storage by walking the entries, which keeps the array inferable as block RAM or MLAB.

Parameters:
- REGADDR_WIDTH, 5, register address width per bank.
- DATA_WIDTH, 32, data word width.
- NUM_REGS, 1<<REGADDR_WIDTH, registers per bank; must be a power of two and at most 1<<REGADDR_WIDTH.
- NUM_READ_PORTS, 2, number of independent read ports; range 1 to 4.
- NUM_BANKS, 1, number of register banks (contexts); must be a power of two.
- BANK_WIDTH, (NUM_BANKS>1) ? $clog2(NUM_BANKS) : 1, bank select width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- readBank  in  NUM_READ_PORTS*BANK_WIDTH  bank select per read port, port p at slice [p*BANK_WIDTH +: BANK_WIDTH].
- readAddr  in  NUM_READ_PORTS*REGADDR_WIDTH  register address per read port, same packing.
- readData  out  NUM_READ_PORTS*DATA_WIDTH  read data per port, valid one cycle after the address.
- writeBank  in  BANK_WIDTH  write bank.
- writeAddr  in  REGADDR_WIDTH  write address.
- writeData  in  DATA_WIDTH  write data.
- writeEnable  in  1  write strobe.
- clearBank  in  BANK_WIDTH  bank to zero on clearStart.
- clearStart  in  1  one-cycle request to zero one bank.
- clearBusy  out  1  high while a clear is in progress.
- clearDone  out  1  one-cycle pulse after the last entry is cleared.

Behaviour:
- Reset (reset high at a posedge):
  - state goes to CLR_ALL and the clear counter goes to 0.
  - readData goes to 0, clearBusy goes to 1, clearDone goes to 0.
  - reset held high keeps the block in the CLR_ALL start condition.
- States:
  - IDLE: normal operation.
  - CLR_ALL: clears every bank.
  - CLR_ONE: clears only clearBank, latched at start.
- IDLE to CLR_ONE:
  - occurs on clearStart.
  - the latched bank is clearBank sampled on the same edge; the counter goes to 0.
- Clear walk:
  - one entry is written with 0 per cycle; the counter spans {bank, addr}.
  - CLR_ONE lasts NUM_REGS cycles.
  - CLR_ALL lasts NUM_BANKS*NUM_REGS cycles.
  - after the final write: return to IDLE, clearBusy falls, and clearDone pulses for one cycle on the same edge.
- clearStart is ignored while clearBusy is high. There is no queueing.
- External writes:
  - while clearBusy is high, writeEnable is ignored for all banks; the write is dropped.
  - in IDLE, writeEnable writes writeData to [writeBank][writeAddr] at the posedge.
- Read latency is exactly 1 cycle. At each posedge every port registers the entry at its {readBank, readAddr}.
- Forwarding (write-first): if a port's {bank, addr} equals an accepted write's {writeBank, writeAddr} on the same edge, that port's next readData is writeData.
- Several ports may read the same entry in the same cycle; all of them get identical data.
- Reads during clear:
  - any port whose bank is being cleared returns 0 on the next cycle, whether or not its entry has been reached yet.
  - in CLR_ALL every bank counts as being cleared.
  - ports reading other banks read normally.
- Simultaneous clearStart and writeEnable in IDLE: the write is performed first, then the clear starts. The write is overwritten only if it targets clearBank.
- Out-of-range addresses (addr >= NUM_REGS): the read returns 0 and the write is dropped.
- The storage array has no reset term. Zeroing happens only through the walk.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - address 0 of every bank is hardwired to zero: reads return 0, and writes to address 0 are dropped.
  - no forwarding applies to address 0.
- Undefined: address 0 is an ordinary register.
- The clear walk and its cycle counts are unchanged in both builds.

Test Plan:
- Reset with NUM_BANKS=2, NUM_REGS=32 -> clearBusy high for exactly 64 cycles; clearDone pulses once; every read returns 0 during and after.
- Idle write bank1 addr5 = 0xDEADBEEF, then read port1 bank1 addr5 one cycle later -> readData port1 = 0xDEADBEEF exactly one cycle after the address; bank0 addr5 reads 0.
- Write bank0 addr7 = 0x12345678 with both read ports at bank0 addr7 on the same edge -> both ports show 0x12345678 on the next cycle (forwarding).
- Fill bank0 and bank1 addr3 with 0xA5A5A5A5, clearStart with clearBank=1 -> clearBusy high for 32 cycles; bank0 addr3 is still 0xA5A5A5A5; bank1 addr3 reads 0; a write issued mid-clear is dropped; a second clearStart mid-clear is ignored.
- Assert reset in the middle of CLR_ONE -> the clear restarts as CLR_ALL; the total busy count restarts from 0; no clearDone pulse from the aborted clear.
- REGFILE_ZERO_REG_EN defined, write addr0 = 0xFFFFFFFF -> addr0 reads 0. Undefined -> addr0 reads 0xFFFFFFFF.
